// File: rtl/fetch_pc_pkg.sv
// fetch_pc shared types and constants.
// Optional misaligned-fetch marker: FETCH_MISALIGN_EN.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    REQ,
    DROP,
    HOLD,
    IDLE
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch-stage signal bundle: redirect in, ibus, decode handshake.
// master = fetch_pc side, slave = bus/decode/branch side.
interface fetch_pc_if;

  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        inst_misalign;

  modport master (
    input  redirect_valid, redirect_pc,
    input  iresp_data_ok, iresp_data,
    input  inst_ready,
    output ireq_valid, ireq_addr,
    output inst_valid, inst, inst_pc,
    output inst_misalign
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output iresp_data_ok, iresp_data,
    output inst_ready,
    input  ireq_valid, ireq_addr,
    input  inst_valid, inst, inst_pc,
    input  inst_misalign
  );

endinterface

// File: rtl/fetch_pc_buf.sv
// fetch_buf: single-entry fetch output register.
// Load wins over flush/consume so a marker can replace a flushed entry.
module fetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] load_inst,
  input  logic [63:0] load_pc,
  input  logic        load_mis,
  output logic        valid,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic        misalign
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      inst     <= '0;
      pc       <= '0;
      misalign <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      inst     <= load_inst;
      pc       <= load_pc;
      misalign <= load_mis;
    end else if (flush || consume) begin
      valid    <= 1'b0;
      misalign <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: PC generator and one-outstanding ibus fetch controller.
// FETCH_MISALIGN_EN: misaligned PC yields a NOP marker, then halts.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  fetch_pc_if.master  bus
);

  function automatic logic [63:0] fetch_addr(input logic [63:0] a);
`ifdef FETCH_MISALIGN_EN
    return a;
`else
    return a & ~64'h3;
`endif
  endfunction

  fetch_state_t state, state_n;
  logic [63:0]  pc, pc_n;
  logic [63:0]  req_addr, req_n;
  logic         ireq_valid_q;

  logic         ld, consume, flush, ld_mis;
  logic [31:0]  ld_inst;
  logic [63:0]  ld_pc;
  logic         go_req;
  logic [63:0]  go_pc;

  logic         buf_valid, buf_mis;
  logic [31:0]  buf_inst;
  logic [63:0]  buf_pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = req_addr;
    ld      = 1'b0;
    ld_inst = bus.iresp_data;
    ld_pc   = req_addr;
    ld_mis  = 1'b0;
    consume = 1'b0;
    flush   = 1'b0;
    go_req  = 1'b0;
    go_pc   = pc;
    if (bus.redirect_valid) begin
      flush = 1'b1;
      pc_n  = bus.redirect_pc;
      unique case (state)
        REQ: begin
          if (bus.iresp_data_ok) begin
            go_req = 1'b1;
            go_pc  = bus.redirect_pc;
          end else begin
            state_n = DROP;
          end
        end
        DROP: ;
        HOLD, IDLE: begin
          go_req = 1'b1;
          go_pc  = bus.redirect_pc;
        end
      endcase
    end else begin
      unique case (state)
        REQ: begin
          if (bus.iresp_data_ok) begin
            ld      = 1'b1;
            pc_n    = pc + 64'd4;
            state_n = HOLD;
          end
        end
        DROP: begin
          if (bus.iresp_data_ok) go_req = 1'b1;
        end
        HOLD: begin
          if (buf_valid && bus.inst_ready) begin
            consume = 1'b1;
            if (buf_mis) state_n = IDLE;
            else go_req = 1'b1;
          end
        end
        IDLE: ;
      endcase
    end
    // Every entry into REQ funnels through here.
    if (go_req) begin
      state_n = REQ;
      req_n   = fetch_addr(go_pc);
`ifdef FETCH_MISALIGN_EN
      if (go_pc[1:0] != 2'b00) begin
        ld      = 1'b1;
        ld_inst = FETCH_NOP;
        ld_pc   = go_pc;
        ld_mis  = 1'b1;
        state_n = HOLD;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= REQ;
      pc           <= RESET_PC;
      req_addr     <= fetch_addr(RESET_PC);
      ireq_valid_q <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      req_addr     <= req_n;
      ireq_valid_q <= (state_n == REQ) || (state_n == DROP);
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (ld),
    .consume   (consume),
    .flush     (flush),
    .load_inst (ld_inst),
    .load_pc   (ld_pc),
    .load_mis  (ld_mis),
    .valid     (buf_valid),
    .inst      (buf_inst),
    .pc        (buf_pc),
    .misalign  (buf_mis)
  );

  assign bus.ireq_valid = ireq_valid_q;
  assign bus.ireq_addr  = req_addr;
  assign bus.inst_valid = buf_valid;
  assign bus.inst       = buf_inst;
  assign bus.inst_pc    = buf_pc;
`ifdef FETCH_MISALIGN_EN
  assign bus.inst_misalign = buf_mis;
`else
  assign bus.inst_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc with a decode-side scoreboard.
// Build with FETCH_MISALIGN_EN to exercise the marker path.
module tb_fetch_pc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_pc_if bus ();

  fetch_pc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] ADDI = 32'h0010_0093;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Decode-side scoreboard: every accepted instruction must be expected.
  always @(negedge clk) begin
    if (!reset && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got inst=%h pc=%h", bus.inst, bus.inst_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.inst !== e.inst || bus.inst_pc !== e.pc
            || bus.inst_misalign !== e.mis) begin
          errors++;
          $display("FAIL sb_inst got %h/%h/%b exp %h/%h/%b",
                   bus.inst, bus.inst_pc, bus.inst_misalign,
                   e.inst, e.pc, e.mis);
        end
      end
    end
  end

  task automatic apply_reset();
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.iresp_data_ok  = 1'b0;
    bus.iresp_data     = '0;
    bus.inst_ready     = 1'b1;
    q.delete();
    cyc();
    cyc();
  endtask

  task automatic fetch_one(input logic [63:0] addr, input logic [31:0] data);
    int n = 0;
    while (!bus.ireq_valid && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== addr) begin
      errors++;
      $display("FAIL fetch_req got v=%b addr=%h exp addr=%h",
               bus.ireq_valid, bus.ireq_addr, addr);
    end
    q.push_back('{data, addr, 1'b0});
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = data;
    cyc();
    bus.iresp_data_ok = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== addr) begin
      errors++;
      $display("FAIL fetch_buf got v=%b pc=%h exp v=1 pc=%h",
               bus.inst_valid, bus.inst_pc, addr);
    end
    cyc();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.ireq_valid !== 1'b0 || bus.inst_valid !== 1'b0
        || bus.inst !== 32'h0 || bus.inst_pc !== 64'h0
        || bus.inst_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got req=%b v=%b inst=%h pc=%h mis=%b",
               bus.ireq_valid, bus.inst_valid, bus.inst, bus.inst_pc,
               bus.inst_misalign);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL reset_first_req got v=%b addr=%h exp 1/80000000",
               bus.ireq_valid, bus.ireq_addr);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a;
      a = 64'h8000_0000 + 64'(i * 4);
      checks++;
      if (bus.ireq_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_rate fetch %0d got ireq_valid=%b exp 1",
                 i, bus.ireq_valid);
      end
      fetch_one(a, ADDI);
    end
  endtask

  task automatic test_redirect_drop();
    apply_reset();
    reset = 1'b0;
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0080;
    cyc();
    bus.redirect_pc    = 64'h8000_0100;
    checks++;
    if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL drop_hold1 got v=%b addr=%h exp 1/80000000",
               bus.ireq_valid, bus.ireq_addr);
    end
    cyc();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.ireq_addr !== 64'h8000_0000 || bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_hold2 got addr=%h v=%b exp 80000000/0",
               bus.ireq_addr, bus.inst_valid);
    end
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'hDEAD_BEEF;
    cyc();
    bus.iresp_data_ok = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.ireq_valid !== 1'b1
        || bus.ireq_addr !== 64'h8000_0100) begin
      errors++;
      $display("FAIL drop_resume got v=%b req=%b addr=%h exp 0/1/80000100",
               bus.inst_valid, bus.ireq_valid, bus.ireq_addr);
    end
    fetch_one(64'h8000_0100, 32'h0020_0113);
  endtask

  task automatic test_redirect_ok();
    bus.iresp_data_ok  = 1'b1;
    bus.iresp_data     = 32'hBAD0_0001;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0300;
    cyc();
    bus.iresp_data_ok  = 1'b0;
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.ireq_valid !== 1'b1
        || bus.ireq_addr !== 64'h8000_0300) begin
      errors++;
      $display("FAIL redir_ok got v=%b req=%b addr=%h exp 0/1/80000300",
               bus.inst_valid, bus.ireq_valid, bus.ireq_addr);
    end
    fetch_one(64'h8000_0300, 32'h0030_0193);
  endtask

  task automatic test_hold();
    bus.inst_ready = 1'b0;
    q.push_back('{32'h0040_0213, 64'h8000_0304, 1'b0});
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'h0040_0213;
    cyc();
    bus.iresp_data_ok = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus.ireq_valid !== 1'b0 || bus.inst_valid !== 1'b1
          || bus.inst !== 32'h0040_0213 || bus.inst_pc !== 64'h8000_0304) begin
        errors++;
        $display("FAIL hold_stable c%0d got req=%b v=%b inst=%h pc=%h",
                 c, bus.ireq_valid, bus.inst_valid, bus.inst, bus.inst_pc);
      end
      if (c == 3) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0400;
      end
      cyc();
    end
    bus.redirect_valid = 1'b0;
    void'(q.pop_front());
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.ireq_valid !== 1'b1
        || bus.ireq_addr !== 64'h8000_0400) begin
      errors++;
      $display("FAIL hold_flush got v=%b req=%b addr=%h exp 0/1/80000400",
               bus.inst_valid, bus.ireq_valid, bus.ireq_addr);
    end
    cyc();
    cyc();
    bus.inst_ready = 1'b1;
    fetch_one(64'h8000_0400, 32'h0050_0293);
  endtask

  task automatic test_wrap();
    bus.iresp_data_ok  = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    bus.iresp_data_ok  = 1'b0;
    bus.redirect_valid = 1'b0;
    fetch_one(64'hFFFF_FFFF_FFFF_FFFC, ADDI);
    checks++;
    if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h0) begin
      errors++;
      $display("FAIL wrap got v=%b addr=%h exp 1/0",
               bus.ireq_valid, bus.ireq_addr);
    end
    fetch_one(64'h0, ADDI);
  endtask

  task automatic test_misalign();
    bus.iresp_data_ok  = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0102;
`ifdef FETCH_MISALIGN_EN
    bus.inst_ready     = 1'b0;
`endif
    cyc();
    bus.iresp_data_ok  = 1'b0;
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
    checks++;
    if (bus.ireq_valid !== 1'b0 || bus.inst_valid !== 1'b1
        || bus.inst_misalign !== 1'b1 || bus.inst !== 32'h0000_0013
        || bus.inst_pc !== 64'h8000_0102) begin
      errors++;
      $display("FAIL mis_marker got req=%b v=%b mis=%b inst=%h pc=%h",
               bus.ireq_valid, bus.inst_valid, bus.inst_misalign,
               bus.inst, bus.inst_pc);
    end
    q.push_back('{32'h0000_0013, 64'h8000_0102, 1'b1});
    bus.inst_ready = 1'b1;
    cyc();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.ireq_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL mis_idle c%0d got req=%b v=%b exp 0/0",
                 c, bus.ireq_valid, bus.inst_valid);
      end
      cyc();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0200;
    cyc();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0200) begin
      errors++;
      $display("FAIL mis_resume got v=%b addr=%h exp 1/80000200",
               bus.ireq_valid, bus.ireq_addr);
    end
    fetch_one(64'h8000_0200, ADDI);
`else
    checks++;
    if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0100
        || bus.inst_misalign !== 1'b0) begin
      errors++;
      $display("FAIL mis_force got v=%b addr=%h mis=%b exp 1/80000100/0",
               bus.ireq_valid, bus.ireq_addr, bus.inst_misalign);
    end
    fetch_one(64'h8000_0100, ADDI);
    checks++;
    if (bus.ireq_addr !== 64'h8000_0104) begin
      errors++;
      $display("FAIL mis_next got addr=%h exp 80000104", bus.ireq_addr);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_redirect_drop();
    test_redirect_ok();
    test_hold();
    test_wrap();
    test_misalign();
    cyc();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
